// File: rtl/instr_fetch.sv
// Purpose : fetch stage; owns the PC, reads instrMem combinationally, fills the IF/ID slot.
// Latency : 1 cycle pc->IF/ID; first capture 2 edges after reset; redirect costs one bubble.
// Backpr. : IF/ID holds stable while id_valid && !id_ready; pc and fetch_count stall with it.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   pc                - registered byte address to instrMem (word index pc[31:2])
//   instr_in          - instruction word for the current pc
//   redirect_valid/pc - taken branch/jump: flush IF/ID and reload pc
//   halt_req          - stop fetching (enter HALTED)
//   id_ready/id_valid - handshake toward decode
//   id_instr, id_pc, id_pc_plus4 - IF/ID payload
//   fetch_count       - captures since reset (wraps)
//   misalign_fault    - sticky misaligned-redirect flag
//
// Build option: FETCH_ALIGN_CHECK_EN. When defined, a misaligned redirect
// target halts fetch and raises misalign_fault. Otherwise the low two bits of
// the target are dropped and misalign_fault stays 0.

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d, id_instr_d, id_pc_d, id_pc_plus4_d, fetch_count_d;
    logic        id_valid_d, fault_q, fault_d;

    logic        accept;
    logic        redirect_ok;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    // Slot is free, or its current occupant leaves this cycle.
    assign accept          = !id_valid || id_ready;
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_ok = (redirect_pc[1:0] == 2'b00);
`else
    // Without the check every target is accepted with its low bits dropped,
    // so fault_q can never set and misalign_fault reduces to constant 0.
    assign redirect_ok = 1'b1;
`endif

    assign misalign_fault = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= 32'd0;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
            fetch_count <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            id_valid    <= id_valid_d;
            id_instr    <= id_instr_d;
            id_pc       <= id_pc_d;
            id_pc_plus4 <= id_pc_plus4_d;
            fetch_count <= fetch_count_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        id_valid_d    = id_valid;
        id_instr_d    = id_instr;
        id_pc_d       = id_pc;
        id_pc_plus4_d = id_pc_plus4;
        fetch_count_d = fetch_count;
        fault_d       = fault_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (redirect_valid) begin
                    // Flush wins over any pending handshake; halt_req is dropped.
                    id_valid_d = 1'b0;
                    if (redirect_ok) begin
                        pc_d = redirect_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end
                end else if (halt_req) begin
                    state_d = HALTED;
                    if (id_ready) id_valid_d = 1'b0;
                end else if (accept) begin
                    id_instr_d    = instr_in;
                    id_pc_d       = pc;
                    id_pc_plus4_d = pc_plus4;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_plus4;
                    fetch_count_d = fetch_count + 32'd1;
                end
            end

            HALTED: begin
                if (redirect_valid) begin
                    id_valid_d = 1'b0;
                    if (redirect_ok) begin
                        pc_d    = redirect_target;
                        state_d = RUN;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (id_ready) begin
                    id_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose : self-checking bench for instr_fetch: directed fetch/stall/redirect/halt/
//           misalign sequence pinned by literals, then random traffic with mid-run resets,
//           all compared every cycle against a behavioural model.

module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] fetch_count;
    logic        misalign_fault;

    // Second instance exercising the PC wrap from the top of the address space.
    logic [31:0] w_pc, w_instr_in, w_id_instr, w_id_pc, w_id_pc_plus4, w_fetch_count;
    logic        w_id_valid, w_misalign_fault;

    int n_vec;
    int n_err;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instr_in       (instr_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_count    (fetch_count),
        .misalign_fault (misalign_fault)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk            (clk),
        .reset          (reset),
        .pc             (w_pc),
        .instr_in       (w_instr_in),
        .redirect_valid (1'b0),
        .redirect_pc    (32'd0),
        .halt_req       (1'b0),
        .id_ready       (1'b1),
        .id_valid       (w_id_valid),
        .id_instr       (w_id_instr),
        .id_pc          (w_id_pc),
        .id_pc_plus4    (w_id_pc_plus4),
        .fetch_count    (w_fetch_count),
        .misalign_fault (w_misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word i holds 32'hA0 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA0 + {2'b00, addr[31:2]};
    endfunction

    always_comb instr_in   = mem_word(pc);
    always_comb w_instr_in = mem_word(w_pc);

    // ---------------- behavioural model ----------------
    // m_mode: 0 = just out of reset, 1 = fetching, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_idpc, m_count;
    logic        m_valid, m_fault;

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'd0;
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_idpc  = 32'd0;
        m_count = 32'd0;
        m_fault = 1'b0;
    endtask

    function automatic bit target_aligned(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return t[1:0] == 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (redirect_valid) begin
            m_valid = 1'b0;
            if (target_aligned(redirect_pc)) begin
                m_pc   = tgt;
                m_mode = 1;
            end else begin
                m_fault = 1'b1;
                m_mode  = 2;
            end
        end else if (m_mode == 2) begin
            if (id_ready) m_valid = 1'b0;
        end else if (halt_req) begin
            m_mode = 2;
            if (id_ready) m_valid = 1'b0;
        end else if (!m_valid || id_ready) begin
            m_instr = mem_word(m_pc);
            m_idpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("pc",          pc,                  m_pc);
        chk("id_valid",    {31'd0, id_valid},   {31'd0, m_valid});
        chk("fetch_count", fetch_count,         m_count);
        chk("fault",       {31'd0, misalign_fault}, {31'd0, m_fault});
        if (m_valid) begin
            chk("id_pc",       id_pc,       m_idpc);
            chk("id_instr",    id_instr,    m_instr);
            chk("id_pc_plus4", id_pc_plus4, m_idpc + 32'd4);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"},       pc,                  32'd0);
        chk({tag, "_valid"},    {31'd0, id_valid},   32'd0);
        chk({tag, "_count"},    fetch_count,         32'd0);
        chk({tag, "_fault"},    {31'd0, misalign_fault}, 32'd0);
        chk({tag, "_id_pc"},    id_pc,               32'd0);
        chk({tag, "_id_instr"}, id_instr,            32'd0);
        chk({tag, "_w_pc"},     w_pc,                32'hFFFF_FFFC);
    endtask

    // Directed inputs for the edge following cycle e.
    task automatic directed_inputs(input int e);
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        case (e)
            5, 6, 7: id_ready = 1'b0;
            9:  begin id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; end
            11: halt_req = 1'b1;
            17: begin redirect_valid = 1'b1; redirect_pc = 32'h0; end
            19: begin redirect_valid = 1'b1; redirect_pc = 32'h42; end
            default: ;
        endcase
    endtask

    // Literal expectations after edge e of the directed phase.
    task automatic directed_checks(input int e);
        case (e)
            2: begin
                chk("e2_valid", {31'd0, id_valid}, 32'd1);
                chk("e2_id_pc", id_pc, 32'd0);
                chk("e2_instr", id_instr, 32'hA0);
                chk("wrap_id_pc",    w_id_pc, 32'hFFFF_FFFC);
                chk("wrap_plus4",    w_id_pc_plus4, 32'd0);
                chk("wrap_valid",    {31'd0, w_id_valid}, 32'd1);
                chk("wrap_instr",    w_id_instr, 32'h4000_009F);
                chk("wrap_pc",       w_pc, 32'd0);
                chk("wrap_count",    w_fetch_count, 32'd1);
                chk("wrap_fault",    {31'd0, w_misalign_fault}, 32'd0);
            end
            3: chk("wrap_id_pc2", w_id_pc, 32'd0);
            5: begin
                chk("e5_id_pc", id_pc, 32'd12);
                chk("e5_plus4", id_pc_plus4, 32'd16);
                chk("e5_count", fetch_count, 32'd4);
            end
            8: begin
                chk("stall_id_pc", id_pc, 32'd12);
                chk("stall_pc",    pc, 32'd16);
                chk("stall_count", fetch_count, 32'd4);
                chk("stall_valid", {31'd0, id_valid}, 32'd1);
            end
            9: begin
                chk("unstall_id_pc", id_pc, 32'd16);
                chk("unstall_count", fetch_count, 32'd5);
            end
            10: begin
                chk("redir_valid", {31'd0, id_valid}, 32'd0);
                chk("redir_pc",    pc, 32'h40);
            end
            11: begin
                chk("redir_id_pc", id_pc, 32'h40);
                chk("redir_instr", id_instr, 32'hB0);
            end
            17: begin
                chk("halt_pc",    pc, 32'h44);
                chk("halt_count", fetch_count, 32'd6);
                chk("halt_valid", {31'd0, id_valid}, 32'd0);
            end
            18: chk("resume_pc", pc, 32'd0);
            19: begin
                chk("resume_id_pc", id_pc, 32'd0);
                chk("resume_valid", {31'd0, id_valid}, 32'd1);
                chk("resume_count", fetch_count, 32'd7);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            20: begin
                chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
                chk("mis_pc",    pc, 32'd4);
                chk("mis_valid", {31'd0, id_valid}, 32'd0);
            end
            21: begin
                chk("mis_halted_valid", {31'd0, id_valid}, 32'd0);
                chk("mis_halted_pc",    pc, 32'd4);
            end
`else
            20: begin
                chk("mis_fault", {31'd0, misalign_fault}, 32'd0);
                chk("mis_pc",    pc, 32'h40);
            end
            21: begin
                chk("mis_cap_valid", {31'd0, id_valid}, 32'd1);
                chk("mis_cap_id_pc", id_pc, 32'h40);
            end
`endif
            default: ;
        endcase
    endtask

    task automatic random_inputs();
        id_ready       = ($urandom_range(0, 3) != 0);
        halt_req       = ($urandom_range(0, 9) == 0);
        redirect_valid = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0)
            redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else
            redirect_pc = $urandom & 32'hFF;
`ifdef FETCH_ALIGN_CHECK_EN
        // Keep most targets aligned so fetch is not parked in HALTED forever.
        if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
`endif
    endtask

    localparam int DIRECTED_END = 22;
    localparam int LAST_CYCLE   = 3000;

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        for (int e = 0; e <= LAST_CYCLE; e++) begin
            if (e > 0) @(negedge clk);
            reset = 1'b0;
            compare_model();
            if (e < DIRECTED_END) begin
                directed_checks(e);
                directed_inputs(e);
                model_step();
            end else if ($urandom_range(0, 199) == 0) begin
                // Asynchronous reset in the middle of traffic.
                reset = 1'b1;
                model_reset();
                #1;
                check_reset_values("midreset");
            end else begin
                random_inputs();
                model_step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage that owns the program counter and sits directly upstream of `instrMem`. It drives a byte-addressed `pc` into the combinational instruction memory and captures the returned word into an IF/ID register with a valid/ready handshake toward decode. It supports branch/jump redirect with flush, downstream back-pressure, and a halt state.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  out  32  registered byte address to `instrMem`; memory word index is `pc[31:2]`.
- `instr_in`  in  32  instruction word returned combinationally by `instrMem` for the current `pc`.
- `redirect_valid`  in  1  branch/jump taken; flush and reload PC.
- `redirect_pc`  in  32  redirect target byte address.
- `halt_req`  in  1  stop fetching after the current cycle.
- `id_ready`  in  1  decode can accept the IF/ID contents.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_instr`  out  32  captured instruction.
- `id_pc`  out  32  address the instruction was fetched from.
- `id_pc_plus4`  out  32  `id_pc + 4`, modulo 2^32.
- `fetch_count`  out  32  number of instructions captured since reset; wraps at 2^32.
- `misalign_fault`  out  1  sticky fault flag (see Configuration).

## Operation
- States: BOOT, RUN, HALTED. Reset enters BOOT.
- Reset values: `pc=RESET_PC`; `id_valid=0`; `id_instr`, `id_pc`, `id_pc_plus4`, `fetch_count` all 0; `misalign_fault=0`.
- Reset asserted mid-operation clears everything immediately, with no pending-capture completion.
- BOOT lasts exactly one cycle with no capture, then moves to RUN.
- The internal term `accept = !id_valid || id_ready` is true when the IF/ID slot is free or draining this cycle.
- RUN priority, highest first:
  - `redirect_valid`: `pc<=redirect_pc`, `id_valid<=0` (flush, regardless of `id_ready`), no capture, no count. `halt_req` is ignored that cycle.
  - `halt_req`: go to HALTED; `pc` holds; no capture. `id_valid` clears when `id_ready` is high, otherwise it holds.
  - `accept`: `id_instr<=instr_in`, `id_pc<=pc`, `id_pc_plus4<=pc+4`, `id_valid<=1`, `pc<=pc+4`, `fetch_count<=fetch_count+1`.
  - Otherwise (stalled): all registers hold.
- HALTED:
  - No capture; `pc` holds; `id_valid` drains on `id_ready`.
  - `redirect_valid` sets `pc<=redirect_pc`, flushes, and returns to RUN.
  - `halt_req` has no effect.
- PC arithmetic is 32-bit unsigned and wraps: `pc=32'hFFFF_FFFC` advances to `32'h0000_0000`. `id_pc_plus4` wraps identically.
- IF/ID contents are stable while `id_valid && !id_ready`.

## Timing
- `pc` is a register, so `instr_in` is valid within the same cycle (combinational memory read). Capture happens at the next edge.
- Sequential throughput is 1 instruction/cycle while `id_ready` stays high.
- Redirect latency:
  - Redirect sampled at edge N.
  - `pc=redirect_pc` after edge N.
  - Target instruction in IF/ID (`id_valid=1`) after edge N+1.
  - This is exactly one bubble.
- First capture after reset release: `id_valid=1` after the second rising edge (BOOT edge, then RUN edge), with `id_pc=RESET_PC`.
- `fetch_count` updates on the same edge as the capture.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect (in RUN or HALTED) with `redirect_pc[1:0]!=2'b00` flushes, leaves `pc` unchanged, sets `misalign_fault<=1`, and enters HALTED.
  - `misalign_fault` stays set until reset.
  - Later redirects in HALTED remain subject to the same check.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is forced to `2'b00` on load.
  - `misalign_fault` is tied to 0.

## Test plan
- **Reset and sequential fetch:** preload memory words 0..3 = `32'hA0..A3`, `id_ready=1`, release reset → after edge 2: `id_valid=1`, `id_pc=0`, `id_instr=32'hA0`; after edge 5: `id_pc=12`, `id_pc_plus4=16`, `fetch_count=4`.
- **Stall:** with `id_valid=1`, `id_pc=4`, drive `id_ready=0` for 3 cycles → `id_*`, `pc=8` and `fetch_count` all unchanged. Raise `id_ready` → next edge `id_pc=8`.
- **Redirect during stall:** `id_ready=0`, `redirect_valid=1`, `redirect_pc=32'h40` for one cycle → next edge `id_valid=0`, `pc=32'h40`; following edge `id_pc=32'h40`, `id_instr=mem[16]`.
- **Halt and resume:** `halt_req=1` at `pc=32'h10` → state HALTED, `pc` stays `32'h10`, `fetch_count` frozen for 5 cycles. Redirect to `32'h0` → RUN, `id_pc=0` two edges later.
- **Wrap:** `RESET_PC=32'hFFFF_FFFC` → first capture `id_pc_plus4=0`, then `id_pc=0`.
- **Misaligned redirect:**
  - With the macro: `redirect_pc=32'h42` → `misalign_fault=1`, HALTED, `pc` unchanged.
  - Without the macro: `pc=32'h40`, `misalign_fault=0`.
